// File: rtl/data_mem_ctrl.sv
// Word-organised little-endian data memory with byte/half/word access, load extension and a request/done handshake.
// Latency LATENCY+1 cycles from accept to done; requests seen while busy are dropped. Optional macro: DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic              memwrite,
    input  logic              memread,
    output logic [31:0]       rd,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [31:0]      wd_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic             write_q;
    logic             fault_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      rd_q;

    logic [31:0]      mem_q [DEPTH];

    logic [ADDR_W-3:0] widx;
    logic              misalign;
    logic              fault_d;
    logic [31:0]       word_cur;
    logic [31:0]       wmerge_d;
    logic [31:0]       load_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign widx = addr[ADDR_W-1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault_d = (memread && memwrite) || (size == 2'b11) ||
                     (32'(widx) >= 32'(DEPTH)) || misalign;

    // Faulted requests never reach the memory, so idx_q is always in range here.
    assign word_cur = mem_q[idx_q];
    assign byte_sel = word_cur[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? word_cur[31:16] : word_cur[15:0];

    always_comb begin
        wmerge_d = word_cur;
        load_d   = word_cur;
        case (size_q)
            2'b00: begin
                wmerge_d[{lane_q, 3'b000} +: 8] = wd_q[7:0];
                load_d = {{24{sign_q & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                if (lane_q[1]) wmerge_d[31:16] = wd_q[15:0];
                else           wmerge_d[15:0]  = wd_q[15:0];
                load_d = {{16{sign_q & half_sel[15]}}, half_sel};
            end
            default: begin
                wmerge_d = wd_q;
                load_d   = word_cur;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ACCESS) && write_q && !fault_q) begin
            mem_q[idx_q] <= wmerge_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            wd_q    <= 32'h0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memread || memwrite) begin
                        idx_q   <= addr[IDX_W+1:2];
                        lane_q  <= addr[1:0];
                        wd_q    <= wd;
                        size_q  <= size;
                        sign_q  <= sign;
                        write_q <= memwrite;
                        fault_q <= fault_d;
                        busy_q  <= 1'b1;
                        if (LATENCY > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= ACCESS;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                ACCESS: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= fault_q;
                    if (!fault_q && !write_q) rd_q <= load_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd   = rd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table of requests plus reset-in-WAIT and busy-drop sequences.
module tb_data_mem_ctrl;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 9;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [1:0]        size;
    logic              sign;
    logic              memwrite;
    logic              memread;
    logic [31:0]       rd;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_hold;
    logic [31:0] mem10;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wd(wd), .size(size), .sign(sign),
        .memwrite(memwrite), .memread(memread), .rd(rd), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        string             name;
        logic              rq;
        logic              wq;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [1:0]        sz;
        logic              sg;
        logic              exp_err;
        logic [31:0]       exp_rd;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_req();
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    // Waits for done after the accept edge; returns the number of edges taken.
    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) break;
            chk({name, " busy"}, 32'(busy), 32'd1);
        end
        if (!done) begin
            errors++;
            $display("FAIL %s: done timeout got 0 expected 1", name);
        end
    endtask

    task automatic run_req(input vec_t v);
        int cyc;
        @(negedge clk);
        memread = v.rq; memwrite = v.wq; addr = v.a; wd = v.d; size = v.sz; sign = v.sg;
        @(posedge clk); #1;
        drop_req();
        chk({v.name, " busy@accept"}, 32'(busy), 32'd1);
        wait_done(v.name, cyc);
        chk({v.name, " latency"}, 32'(cyc), 32'(LAT + 1));
        chk({v.name, " err"}, 32'(err), 32'(v.exp_err));
        chk({v.name, " busy@done"}, 32'(busy), 32'd0);
        if (v.rq && !v.wq && !v.exp_err) rd_hold = v.exp_rd;
        chk({v.name, " rd"}, rd, rd_hold);
    endtask

    function automatic vec_t mk(string n, logic rq, logic wq, logic [ADDR_W-1:0] a,
                                logic [31:0] d, logic [1:0] sz, logic sg, logic e, logic [31:0] r);
        vec_t v;
        v.name = n; v.rq = rq; v.wq = wq; v.a = a; v.d = d; v.sz = sz; v.sg = sg;
        v.exp_err = e; v.exp_rd = r;
        return v;
    endfunction

    initial begin
        int cyc;
        rst_n = 1'b0; addr = '0; wd = '0; size = 2'b10; sign = 1'b0; drop_req();
        rd_hold = 32'h0;

        vecs.push_back(mk("sw_deadbeef", 0, 1, 9'h010, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0));
        vecs.push_back(mk("lw_deadbeef", 1, 0, 9'h010, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk("sw_11223344", 0, 1, 9'h020, 32'h11223344, 2'b10, 0, 0, 32'h0));
        vecs.push_back(mk("sb_f0", 0, 1, 9'h022, 32'hABCDEFF0, 2'b00, 0, 0, 32'h0));
        vecs.push_back(mk("lb_signed", 1, 0, 9'h022, 32'h0, 2'b00, 1, 0, 32'hFFFFFFF0));
        vecs.push_back(mk("lw_merged", 1, 0, 9'h020, 32'h0, 2'b10, 0, 0, 32'h11F03344));
        vecs.push_back(mk("lbu_f0", 1, 0, 9'h022, 32'h0, 2'b00, 0, 0, 32'h000000F0));
        vecs.push_back(mk("lb_33", 1, 0, 9'h021, 32'h0, 2'b00, 1, 0, 32'h00000033));
        vecs.push_back(mk("sw_12345678", 0, 1, 9'h004, 32'h12345678, 2'b10, 0, 0, 32'h0));
        vecs.push_back(mk("sh_8001", 0, 1, 9'h006, 32'hFFFF8001, 2'b01, 0, 0, 32'h0));
        vecs.push_back(mk("lhu_8001", 1, 0, 9'h006, 32'h0, 2'b01, 0, 0, 32'h00008001));
        vecs.push_back(mk("lh_signed", 1, 0, 9'h006, 32'h0, 2'b01, 1, 0, 32'hFFFF8001));
        vecs.push_back(mk("lw_half_merge", 1, 0, 9'h004, 32'h0, 2'b10, 0, 0, 32'h80015678));
        vecs.push_back(mk("fault_both", 1, 1, 9'h010, 32'h0, 2'b10, 0, 1, 32'h0));
        vecs.push_back(mk("fault_size11", 0, 1, 9'h010, 32'h0, 2'b11, 0, 1, 32'h0));
        vecs.push_back(mk("fault_oob_st", 0, 1, 9'h100, 32'h0, 2'b10, 0, 1, 32'h0));
        vecs.push_back(mk("fault_oob_ld", 1, 0, 9'h100, 32'h0, 2'b10, 0, 1, 32'h0));
        vecs.push_back(mk("lw_after_faults", 1, 0, 9'h010, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF));
`ifdef DMEM_ALIGN_CHECK_EN
        mem10 = 32'hDEADBEEF;
        vecs.push_back(mk("sw_misaligned", 0, 1, 9'h013, 32'hCAFEF00D, 2'b10, 0, 1, 32'h0));
        vecs.push_back(mk("lw_after_misal", 1, 0, 9'h010, 32'h0, 2'b10, 0, 0, mem10));
        vecs.push_back(mk("lh_misaligned", 1, 0, 9'h007, 32'h0, 2'b01, 0, 1, 32'h0));
`else
        mem10 = 32'hCAFEF00D;
        vecs.push_back(mk("sw_misaligned", 0, 1, 9'h013, 32'hCAFEF00D, 2'b10, 0, 0, 32'h0));
        vecs.push_back(mk("lw_after_misal", 1, 0, 9'h010, 32'h0, 2'b10, 0, 0, mem10));
        vecs.push_back(mk("lh_misaligned", 1, 0, 9'h007, 32'h0, 2'b01, 0, 0, 32'h00008001));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rd", rd, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) run_req(vecs[i]);

        // Reset lands while the store is still waiting: nothing must be written.
        @(negedge clk);
        memwrite = 1'b1; addr = 9'h010; wd = 32'h55555555; size = 2'b10;
        @(posedge clk); #1;
        drop_req();
        chk("rstwait busy", 32'(busy), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstwait busy", 32'(busy), 32'd0);
        chk("rstwait done", 32'(done), 32'd0);
        chk("rstwait err", 32'(err), 32'd0);
        chk("rstwait rd", rd, 32'h0);
        rd_hold = 32'h0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rstwait no done", 32'(done), 32'd0);
        end
        run_req(mk("lw_after_rst", 1, 0, 9'h010, 32'h0, 2'b10, 0, 0, mem10));

        // A request presented while busy is dropped, not queued.
        run_req(mk("sw_zero_34", 0, 1, 9'h034, 32'h0, 2'b10, 0, 0, 32'h0));
        @(negedge clk);
        memwrite = 1'b1; addr = 9'h030; wd = 32'h00000077; size = 2'b10;
        @(posedge clk); #1;
        drop_req();
        @(negedge clk);
        memwrite = 1'b1; addr = 9'h034; wd = 32'h00000099;
        @(posedge clk); #1;
        drop_req();
        chk("busydrop busy", 32'(busy), 32'd1);
        wait_done("busydrop", cyc);
        chk("busydrop latency", 32'(cyc + 1), 32'(LAT + 1));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("busydrop idle", 32'(busy), 32'd0);
        end
        run_req(mk("lw_34_unchanged", 1, 0, 9'h034, 32'h0, 2'b10, 0, 0, 32'h0));
        run_req(mk("lw_30_stored", 1, 0, 9'h030, 32'h0, 2'b10, 0, 0, 32'h00000077));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
